// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: takes one FFT frame in bit-reversed bin order and
// replays it in natural bin order behind a valid/ready output register.
module fft_bitrev_reorder #(
    parameter int DATA_WIDTH = 16,
    parameter int N_POINTS   = 16,
    localparam int AW        = $clog2(N_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_val,
    input  logic [DATA_WIDTH-1:0] in_re,
    input  logic [DATA_WIDTH-1:0] in_im,
    input  logic                  out_rdy,
    output logic                  out_val,
    output logic [DATA_WIDTH-1:0] out_re,
    output logic [DATA_WIDTH-1:0] out_im,
    output logic [AW-1:0]         out_idx,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  ovf
);

    localparam logic [AW-1:0] LAST = AW'(N_POINTS - 1);

    logic [DATA_WIDTH-1:0] mem_re [2*N_POINTS];
    logic [DATA_WIDTH-1:0] mem_im [2*N_POINTS];

    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] rd_cnt;
    logic          wr_bank;
    logic          rd_bank;
    logic [1:0]    bank_full;
    logic [1:0]    bank_full_nxt;

    logic wr_fire;
    logic wr_last;
    logic rd_adv;
    logic rd_fire;
    logic rd_last;

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < AW; i++) begin
            r[i] = a[AW-1-i];
        end
        return r;
    endfunction

    // Output handshake: a beat transfers on a clock edge where out_val and
    // out_rdy are both 1; while out_val=1 and out_rdy=0 every out_* is frozen.
    assign wr_fire = in_val && !bank_full[wr_bank];
    assign wr_last = (wr_cnt == LAST);
    assign rd_adv  = !out_val || out_rdy;
    assign rd_fire = rd_adv && bank_full[rd_bank];
    assign rd_last = (rd_cnt == LAST);

    assign out_sop = out_val && (out_idx == '0);
    assign out_eop = out_val && (out_idx == LAST);

    // Writer needs an empty bank and the reader a full one, so a set and a
    // clear in the same cycle always target different bits.
    always_comb begin
        bank_full_nxt = bank_full;
        if (wr_fire && wr_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
        end
        if (rd_fire && rd_last) begin
            bank_full_nxt[rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem_re[{wr_bank, bitrev(wr_cnt)}] <= in_re;
            mem_im[{wr_bank, bitrev(wr_cnt)}] <= in_im;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt    <= '0;
            wr_bank   <= 1'b0;
            bank_full <= 2'b00;
            ovf       <= 1'b0;
        end else begin
            bank_full <= bank_full_nxt;
            if (in_val && bank_full[wr_bank]) begin
                ovf <= 1'b1;
            end
            if (wr_fire) begin
                if (wr_last) begin
                    wr_cnt  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_cnt <= wr_cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
            out_val <= 1'b0;
            out_re  <= '0;
            out_im  <= '0;
            out_idx <= '0;
        end else if (rd_adv) begin
            if (rd_fire) begin
                out_val <= 1'b1;
                out_re  <= mem_re[{rd_bank, rd_cnt}];
                out_im  <= mem_im[{rd_bank, rd_cnt}];
                out_idx <= rd_cnt;
                if (rd_last) begin
                    rd_cnt  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_cnt <= rd_cnt + 1'b1;
                end
            end else begin
                out_val <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Scoreboard bench for fft_bitrev_reorder: directed frames are queued as
// expected natural-order beats and a negedge monitor pops and compares them.
module tb_fft_bitrev_reorder;

    localparam int DW = 16;
    localparam int N  = 16;

    logic          clk;
    logic          rst;
    logic          in_val;
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic          out_rdy;
    logic          out_val;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [3:0]    out_idx;
    logic          out_sop;
    logic          out_eop;
    logic          ovf;

    fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .in_val  (in_val),
        .in_re   (in_re),
        .in_im   (in_im),
        .out_rdy (out_rdy),
        .out_val (out_val),
        .out_re  (out_re),
        .out_im  (out_im),
        .out_idx (out_idx),
        .out_sop (out_sop),
        .out_eop (out_eop),
        .ovf     (ovf)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // beat layout: {eop, sop, idx[3:0], im[15:0], re[15:0]}
    logic [37:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    // bit-reversed write order of bins 0..15, straight from the frame table
    int stim_tbl[16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

    function automatic logic [37:0] mk_beat(input int j, input logic [15:0] base);
        logic [15:0] re;
        re = base + 16'(j);
        return {(j == 15), (j == 0), 4'(j), ~re, re};
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            failures++;
            $display("FAIL %s: got %h, required %h", name, got, req);
        end
    endtask

    // ---------------- monitor ----------------
    logic        hold_valid = 1'b0;
    logic [37:0] hold_snap;
    logic [37:0] cur;
    logic [37:0] exp_b;
    logic        track_gaps = 1'b0;
    logic        seen_first = 1'b0;
    int          gap_cnt    = 0;

    always @(negedge clk) begin
        cur = {out_eop, out_sop, out_idx, out_im, out_re};
        if (!rst) begin
            hold_valid = 1'b0;
        end else begin
            if (hold_valid) begin
                checks++;
                if (cur !== hold_snap || !out_val) begin
                    failures++;
                    $display("FAIL hold_stable: got val=%b beat=%h, required val=1 beat=%h",
                             out_val, cur, hold_snap);
                end
            end
            hold_valid = out_val && !out_rdy;
            hold_snap  = cur;
            if (out_val && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_beat: got idx=%0d re=%h, required no output", out_idx, out_re);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (cur !== exp_b) begin
                        failures++;
                        $display("FAIL out_beat: got eop=%b sop=%b idx=%0d im=%h re=%h, required eop=%b sop=%b idx=%0d im=%h re=%h",
                                 cur[37], cur[36], cur[35:32], cur[31:16], cur[15:0],
                                 exp_b[37], exp_b[36], exp_b[35:32], exp_b[31:16], exp_b[15:0]);
                    end
                end
            end
            if (track_gaps) begin
                if (out_val) seen_first = 1'b1;
                else if (seen_first) gap_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Leaves in_val=1 after the last sample so consecutive calls stream gap-free.
    task automatic send_frame(input logic [15:0] base, input bit push, input int gap, input int n);
        if (push) begin
            for (int j = 0; j < N; j++) exp_q.push_back(mk_beat(j, base));
        end
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            in_val = 1'b1;
            in_re  = base + 16'(stim_tbl[k]);
            in_im  = ~(base + 16'(stim_tbl[k]));
            for (int g = 0; g < gap; g++) begin
                @(posedge clk); #1;
                in_val = 1'b0;
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_val = 1'b0;
        end
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk); #1;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d beats outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // ---------------- stimulus ----------------
    int last_cyc;
    int hit;

    initial begin
        rst     = 1'b0;
        in_val  = 1'b0;
        in_re   = '0;
        in_im   = '0;
        out_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_val", 32'(out_val), 32'd0);
        check("reset_out_re",  32'(out_re),  32'd0);
        check("reset_out_idx", 32'(out_idx), 32'd0);
        check("reset_sop_eop", {30'd0, out_sop, out_eop}, 32'd0);
        check("reset_ovf",     32'(ovf),     32'd0);
        rst = 1'b1;
        idle(2);

        // single frame, latency of bin 0
        send_frame(16'h0000, 1'b1, 0, N);
        last_cyc = cyc;
        @(posedge clk); #1;
        in_val = 1'b0;
        hit = 0;
        for (int i = 0; i < 8 && !hit; i++) begin
            @(negedge clk);
            if (out_val) hit = 1;
        end
        check("first_out_seen", 32'(hit), 32'd1);
        check("first_out_latency", 32'(cyc - last_cyc), 32'd2);
        wait_drain(40, "single");
        idle(3);

        // four frames back to back, no output gap after the first bin
        gap_cnt    = 0;
        seen_first = 1'b0;
        track_gaps = 1'b1;
        send_frame(16'h1000, 1'b1, 0, N);
        send_frame(16'h2000, 1'b1, 0, N);
        send_frame(16'h3000, 1'b1, 0, N);
        send_frame(16'h4000, 1'b1, 0, N);
        idle(1);
        wait_drain(80, "b2b");
        track_gaps = 1'b0;
        check("b2b_gap_cycles", 32'(gap_cnt), 32'd0);
        check("b2b_ovf", 32'(ovf), 32'd0);
        idle(3);

        // sparse input: one sample every third cycle
        send_frame(16'h5000, 1'b1, 2, N);
        idle(1);
        wait_drain(60, "gaps");
        check("gaps_ovf", 32'(ovf), 32'd0);
        idle(3);

        // backpressure held on bin 3 for five cycles
        send_frame(16'h6000, 1'b1, 0, N);
        idle(1);
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (out_val && out_idx == 4'd3) hit = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("bin3_reached", 32'(hit), 32'd1);
        out_rdy = 1'b0;
        for (int h = 0; h < 5; h++) begin
            check("bin3_held_idx", 32'(out_idx), 32'd3);
            check("bin3_held_re",  32'(out_re),  32'h6003);
            @(posedge clk); #1;
        end
        out_rdy = 1'b1;
        wait_drain(40, "bin3");
        idle(3);

        // output stalled for whole frames: third frame is dropped
        out_rdy = 1'b0;
        send_frame(16'h7000, 1'b1, 0, N);
        send_frame(16'h8000, 1'b1, 0, N);
        idle(2);
        check("ovf_before_drop", 32'(ovf), 32'd0);
        send_frame(16'h9000, 1'b0, 0, N);
        idle(2);
        check("ovf_after_drop", 32'(ovf), 32'd1);
        check("stall_front_re", 32'(out_re), 32'h7000);
        out_rdy = 1'b1;
        wait_drain(80, "ovf");
        idle(3);

        // reset in the middle of a frame
        send_frame(16'hA000, 1'b0, 0, 7);
        @(posedge clk); #1;
        in_val = 1'b0;
        rst    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("midrst_out_val", 32'(out_val), 32'd0);
            @(posedge clk); #1;
        end
        check("midrst_ovf_cleared", 32'(ovf), 32'd0);
        rst = 1'b1;
        idle(2);
        send_frame(16'hB000, 1'b1, 0, N);
        idle(1);
        wait_drain(40, "midrst");
        idle(5);
        check("final_idle_val", 32'(out_val), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
